// File: rtl/display_scan_mux.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Feeds one BCD nibble at a time to the decoder with matching active-low anode enables.
module display_scan_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned GHOST      = 2,
    parameter bit          LZ_BLANK   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    output logic                      w,
    output logic                      x,
    output logic                      y,
    output logic                      z,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done,
    output logic                      err
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VW = 4 * NUM_DIGITS;

    logic [CW-1:0]         c_q, c_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    logic [VW-1:0]         disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            nib_q, nib_d;
    logic                  fd_q, fd_d;
    logic                  err_q, err_d;

    logic                  c_last;
    logic                  idx_last;
    logic                  boundary;
    logic                  update;
    logic [VW-1:0]         new_disp;
    logic                  new_bad;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  cur_sup;
    logic                  ghost_done;

    // Prescaler and slot index; the frame boundary is the last count of the last slot.
    always_comb begin
        c_last   = (c_q == CW'(PRESCALE - 1));
        idx_last = (idx_q == IW'(NUM_DIGITS - 1));
        boundary = c_last && idx_last;
        c_d      = c_last ? '0 : c_q + CW'(1);
        idx_d    = idx_q;
        if (c_last) begin
            idx_d = idx_last ? '0 : idx_q + IW'(1);
        end
    end

    // Shadow capture and frame-aligned transfer into the displayed value.
    always_comb begin
        shadow_d  = load ? value : shadow_q;
        pending_d = load | pending_q;
        new_disp  = load ? value : shadow_q;
        update    = boundary && (pending_q || load);
        disp_d    = disp_q;
        err_d     = err_q;
        new_bad   = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (new_disp[4*i +: 4] > 4'd9) begin
                new_bad = 1'b1;
            end
        end
        if (update) begin
            disp_d    = new_disp;
            pending_d = 1'b0;
            err_d     = new_bad;
        end
    end

    // Per-digit suppression: invalid nibble, or part of a leading-zero run (never digit 0).
    always_comb begin
        zero_run = 1'b1;
        suppress = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run    = zero_run && (disp_q[4*i +: 4] == 4'd0);
            suppress[i] = (disp_q[4*i +: 4] > 4'd9) || (LZ_BLANK && (i != 0) && zero_run);
        end
    end

    // Output selection for the current slot; registered so slots lag the counter by one cycle.
    always_comb begin
        ghost_done = (c_q >= CW'(GHOST));
        nib_d      = 4'd0;
        cur_sup    = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                nib_d   = disp_q[4*i +: 4];
                cur_sup = suppress[i];
            end
        end
        an_d = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if ((idx_q == IW'(i)) && ghost_done && !cur_sup) begin
                an_d[i] = 1'b0;
            end
        end
        // Registered pulse lands on the cycle the counter sits at the frame boundary.
        fd_d = idx_last && (c_q == CW'(PRESCALE - 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q       <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            nib_q     <= 4'd0;
            fd_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            c_q       <= c_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            nib_q     <= nib_d;
            fd_q      <= fd_d;
            err_q     <= err_d;
        end
    end

    assign w          = nib_q[3];
    assign x          = nib_q[2];
    assign y          = nib_q[1];
    assign z          = nib_q[0];
    assign an         = an_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: a cycle model queues the expected outputs of every
// clock edge and each one is popped and checked one time unit after that edge.
module tb_display_scan_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned P  = 4;
    localparam int unsigned G  = 1;
    localparam bit          LZ = 1'b1;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [15:0]   value;
    logic          w, x, y, z;
    logic [3:0]    an;
    logic          frame_done;
    logic          err;

    int            n_pass;
    int            n_total;
    int            cycle;

    int            m_c;
    int            m_idx;
    logic [15:0]   m_shadow;
    logic [15:0]   m_disp;
    bit            m_pend;
    bit            m_err;

    logic [9:0]    sb_q[$];

    display_scan_mux #(
        .NUM_DIGITS(N),
        .PRESCALE  (P),
        .GHOST     (G),
        .LZ_BLANK  (LZ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
        .an        (an),
        .frame_done(frame_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] digit_of(logic [15:0] d, int i);
        logic [15:0] s;
        s = d >> (4 * i);
        return s[3:0];
    endfunction

    // Digits i..N-1 are all zero exactly when the value shifted down by i digits is zero.
    function automatic bit suppressed(logic [15:0] d, int i);
        return (digit_of(d, i) > 4'd9) || (LZ && (i != 0) && ((d >> (4 * i)) == 16'd0));
    endfunction

    function automatic logic [3:0] exp_an(int c, int i, logic [15:0] d);
        logic [3:0] a;
        a = 4'b1111;
        if ((c >= int'(G)) && !suppressed(d, i)) a[i] = 1'b0;
        return a;
    endfunction

    function automatic bit has_bad(logic [15:0] d);
        bit b;
        b = 1'b0;
        for (int i = 0; i < int'(N); i++) if (digit_of(d, i) > 4'd9) b = 1'b1;
        return b;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    endtask

    task automatic model_reset();
        m_c = 0; m_idx = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0; m_err = 1'b0;
    endtask

    // One clock: predict this edge's outputs, queue them, then compare after the edge.
    task automatic tick();
        int          nc, ni;
        logic [15:0] ns, nd;
        bit          np, ne, bnd;
        logic [9:0]  e;
        logic [9:0]  got;
        bnd = (m_c == int'(P) - 1) && (m_idx == int'(N) - 1);
        nc  = (m_c == int'(P) - 1) ? 0 : m_c + 1;
        ni  = (m_c == int'(P) - 1) ? ((m_idx == int'(N) - 1) ? 0 : m_idx + 1) : m_idx;
        ns  = load ? value : m_shadow;
        np  = load ? 1'b1 : m_pend;
        nd  = m_disp;
        ne  = m_err;
        if (bnd && (m_pend || load)) begin
            nd = load ? value : m_shadow;
            np = 1'b0;
            ne = has_bad(nd);
        end
        e = {exp_an(m_c, m_idx, m_disp), digit_of(m_disp, m_idx),
             1'((nc == int'(P) - 1) && (ni == int'(N) - 1)), ne};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {an, w, x, y, z, frame_done, err};
        check("scan", 16'(got), 16'(sb_q.pop_front()));
        m_c = nc; m_idx = ni; m_shadow = ns; m_disp = nd; m_pend = np; m_err = ne;
        cycle++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0; cycle = 0;
        rst_n = 1'b0; load = 1'b0; value = '0;
        model_reset();

        // Reset values held while rst_n is low.
        #12;
        check("rst_an", 16'(an), 16'hF);
        check("rst_wxyz", 16'({w, x, y, z}), 16'h0);
        check("rst_fd_err", 16'({frame_done, err}), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First two frames after reset: only digit 0 lit, frame_done every 16 cycles.
        run(32);

        // Load mid-frame; the current frame stays untouched, 1234 appears next frame.
        run(5);
        do_load(16'h1234);
        run(40);

        // Leading-zero blanking.
        do_load(16'h0070);
        run(40);
        do_load(16'h0000);
        run(40);

        // Invalid digit raises err and blanks that slot; a valid load clears it.
        do_load(16'h12A4);
        run(40);
        check("err_set", 16'(err), 16'h1);
        do_load(16'h1234);
        run(40);
        check("err_clr", 16'(err), 16'h0);

        // Load coinciding with the frame boundary.
        for (int k = 0; k < 64 && !((m_c == int'(P) - 1) && (m_idx == int'(N) - 1)); k++) tick();
        check("fd_at_boundary", 16'(frame_done), 16'h1);
        do_load(16'h5678);
        run(20);

        // Two loads in one frame: the later one wins.
        run(3);
        do_load(16'h1111);
        run(4);
        do_load(16'h2222);
        run(40);

        // Asynchronous reset at count 2 of slot 2.
        for (int k = 0; k < 64 && !((m_c == 2) && (m_idx == 2)); k++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_an", 16'(an), 16'hF);
        check("arst_wxyz", 16'({w, x, y, z}), 16'h0);
        check("arst_fd_err", 16'({frame_done, err}), 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(20);

        check("sb_empty", 16'(sb_q.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
